// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : quad_decoder
//  Description : Multi-channel quadrature rotary-encoder decoder with push
//                buttons. Every raw input goes through a 2-flop synchronizer
//                and then a debouncer. The debounced phases are decoded into
//                signed steps. Steps are gathered into detent pulses (cw/ccw),
//                and a per-channel position counter saturates at its limits.
//                Buttons give a press pulse on the debounced falling edge.
//  Optional    : define QUAD_DECODER_LONG_PRESS_EN to build a per-channel
//                hold counter. It produces one long-press pulse (lp) after
//                LONG_TICKS cycles of debounced hold. Without the macro, lp
//                is tied to 0.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                a, b   - raw quadrature phases, one bit per channel
//                btn    - raw active-low push buttons, one bit per channel
//                clr    - synchronous position clear, one bit per channel
//                cw/ccw - one-cycle detent pulses
//                err    - one-cycle pulse on an illegal (double) transition
//                prs/lp - one-cycle press / long-press pulses
//                pos    - packed signed positions, channel 0 in the LSBs
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_decoder #(
    parameter int CHANNELS         = 1,
    parameter int DEBOUNCE_TICKS   = 10000,
    parameter int STEPS_PER_DETENT = 4,
    parameter int CNT_W            = 16,
    parameter int LONG_TICKS       = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    input  logic [CHANNELS-1:0]       btn,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS-1:0]       cw,
    output logic [CHANNELS-1:0]       ccw,
    output logic [CHANNELS-1:0]       err,
    output logic [CHANNELS-1:0]       prs,
    output logic [CHANNELS-1:0]       lp,
    output logic [CHANNELS*CNT_W-1:0] pos
);

    localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

    localparam logic signed [3:0] ACC_P = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] ACC_N = -ACC_P;

    localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    // Bit order of the per-channel input bundle: {btn, b, a}.
    // Button sync/debounce flops reset to the released level. This avoids a
    // false press while the synchronizer fills after reset.
    localparam logic [2:0] IN_RST = 3'b100;

`ifdef QUAD_DECODER_LONG_PRESS_EN
    localparam int LP_W = $clog2(LONG_TICKS + 1);
    localparam logic [LP_W-1:0] LP_FULL = LP_W'(LONG_TICKS);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_TICKS - 1);
`else
    logic unused_long;
    assign unused_long = (LONG_TICKS > 0);
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

        logic [2:0]          raw;
        logic [2:0]          sync1;
        logic [2:0]          sync2;
        logic [2:0]          db;
        logic [2:0]          prev;
        logic [DB_W-1:0]     dcnt [3];
        logic signed [3:0]   acc;
        logic                cw_q;
        logic                ccw_q;
        logic                err_q;
        logic                prs_q;
        logic signed [CNT_W-1:0] pos_q;

        logic [1:0]          ph_prev;
        logic [1:0]          ph_cur;
        logic [1:0]          cw_nxt;
        logic signed [3:0]   step;
        logic signed [3:0]   acc_sum;
        logic signed [3:0]   acc_d;
        logic                cw_d;
        logic                ccw_d;
        logic                err_d;

        assign raw = {btn[i], b[i], a[i]};

        // Phase decode. The state is {a,b}, and clockwise runs
        // 00->10->11->01->00.
        always_comb begin
            ph_prev = {prev[0], prev[1]};
            ph_cur  = {db[0], db[1]};
            case (ph_prev)
                2'b00:   cw_nxt = 2'b10;
                2'b10:   cw_nxt = 2'b11;
                2'b11:   cw_nxt = 2'b01;
                default: cw_nxt = 2'b00;
            endcase
            step    = 4'sd0;
            acc_sum = acc;
            acc_d   = acc;
            cw_d    = 1'b0;
            ccw_d   = 1'b0;
            err_d   = 1'b0;
            if (ph_cur != ph_prev) begin
                if (ph_cur == ~ph_prev) begin
                    // Both phases moved together. The direction is unknown,
                    // so the accumulator is left untouched.
                    err_d = 1'b1;
                end else begin
                    step    = (ph_cur == cw_nxt) ? 4'sd1 : -4'sd1;
                    acc_sum = acc + step;
                    if (acc_sum == ACC_P) begin
                        cw_d  = 1'b1;
                        acc_d = 4'sd0;
                    end else if (acc_sum == ACC_N) begin
                        ccw_d = 1'b1;
                        acc_d = 4'sd0;
                    end else if (ph_cur == 2'b00) begin
                        // Resync at the mechanical detent. Missed steps
                        // must not build up across detents.
                        acc_d = 4'sd0;
                    end else begin
                        acc_d = acc_sum;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= IN_RST;
                sync2 <= IN_RST;
                db    <= IN_RST;
                prev  <= IN_RST;
                for (int k = 0; k < 3; k++) begin
                    dcnt[k] <= '0;
                end
                acc   <= 4'sd0;
                cw_q  <= 1'b0;
                ccw_q <= 1'b0;
                err_q <= 1'b0;
                prs_q <= 1'b0;
                pos_q <= '0;
            end else begin
                sync1 <= raw;
                sync2 <= sync1;
                prev  <= db;
                for (int k = 0; k < 3; k++) begin
                    if (sync2[k] == db[k]) begin
                        dcnt[k] <= '0;
                    end else if (dcnt[k] == DB_LAST) begin
                        db[k]   <= sync2[k];
                        dcnt[k] <= '0;
                    end else begin
                        dcnt[k] <= dcnt[k] + DB_W'(1);
                    end
                end
                acc   <= acc_d;
                cw_q  <= cw_d;
                ccw_q <= ccw_d;
                err_q <= err_d;
                prs_q <= prev[2] & ~db[2];
                // The position follows the registered detent pulses. A clear
                // in the same cycle as a pulse therefore takes priority.
                if (clr[i]) begin
                    pos_q <= '0;
                end else if (cw_q) begin
                    if (pos_q != POS_MAX) pos_q <= pos_q + CNT_W'(1);
                end else if (ccw_q) begin
                    if (pos_q != POS_MIN) pos_q <= pos_q - CNT_W'(1);
                end
            end
        end

        assign cw[i]  = cw_q;
        assign ccw[i] = ccw_q;
        assign err[i] = err_q;
        assign prs[i] = prs_q;
        assign pos[i*CNT_W +: CNT_W] = pos_q;

`ifdef QUAD_DECODER_LONG_PRESS_EN
        logic [LP_W-1:0] hold;
        logic            lp_q;

        // The hold counter stops at LONG_TICKS. The pulse therefore fires
        // once per press, however long the button stays down.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold <= '0;
                lp_q <= 1'b0;
            end else begin
                if (db[2]) begin
                    hold <= '0;
                end else if (hold != LP_FULL) begin
                    hold <= hold + LP_W'(1);
                end
                lp_q <= ~db[2] & (hold == LP_LAST);
            end
        end

        assign lp[i] = lp_q;
`else
        assign lp[i] = 1'b0;
`endif
    end : g_ch

endmodule
`default_nettype wire
